// File: rtl/dpram_pkg.sv
// rtl/dpram_pkg.sv - shared constants and types for the distributed dual-port RAM blocks
// Contents: default geometry of the RAM32X1D array (shared with the writer side)
//           and the reader FSM state encoding.

package dpram_pkg;

  // Depth 2^5 = 32 matches one RAM32X1D; width is the number of bit slices.
  localparam int DEF_AW = 5;
  localparam int DEF_DW = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/dpram_reader_if.sv
// rtl/dpram_reader_if.sv - command, RAM read-port and output-stream bundle of dpram_reader
// Signals:
//   cmd_valid/cmd_ready/cmd_addr/cmd_len  start-address / word-count-minus-one command
//   rd_addr/rd_data                       DPRA / DPO of every RAM slice
//   out_valid/out_ready/out_data/out_last output word stream
//   busy                                  command in flight or word pending
// Modports: slave = the reader itself, master = the environment driving it.

interface dpram_reader_if
  import dpram_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, rd_data, out_ready,
    output cmd_ready, rd_addr, out_valid, out_data, out_last, busy
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len, rd_data, out_ready,
    input  cmd_ready, rd_addr, out_valid, out_data, out_last, busy
  );

endinterface

// File: rtl/dpram_reader.sv
// rtl/dpram_reader.sv - read-side streaming engine for a bit-sliced RAM32X1D array
// Ports:
//   clk     sole clock (same net as the RAM WCLK)
//   nreset  asynchronous active-low reset
//   bus     dpram_reader_if.slave: command in, DPRA out / DPO in, word stream out
// Each accepted command streams cmd_len+1 words starting at cmd_addr, wrapping
// modulo 2^AW, with out_last on the final word.

module dpram_reader
  import dpram_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic           clk,
  input  logic           nreset,
  dpram_reader_if.slave  bus
);

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] rem_q;
  logic [DW-1:0] data_q;
  logic          valid_q;
  logic          last_q;
  logic          slot_free;

  // The output register can take a new word when empty or being drained this cycle.
  assign slot_free = !valid_q || bus.out_ready;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // The final word of the previous command may still be draining.
          if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
          end
          if (bus.cmd_valid) begin
            addr_q <= bus.cmd_addr;
            rem_q  <= bus.cmd_len;
            state  <= STREAM;
          end
        end
        STREAM: begin
          // rd_addr has been stable since the previous edge, so DPO is settled.
          // A same-edge write to addr_q is not bypassed: the old content is taken.
          if (slot_free) begin
            data_q  <= bus.rd_data;
            valid_q <= 1'b1;
            last_q  <= (rem_q == '0);
            addr_q  <= AW'(addr_q + 1'b1);
            rem_q   <= AW'(rem_q - 1'b1);
            if (rem_q == '0) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_addr   = addr_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state == STREAM) || valid_q;

endmodule

// File: doc/dpram_reader.md
# dpram_reader

Read-side streaming engine for the 32-deep distributed dual-port RAM primitives (RAM32X1D and bit-sliced arrays of it). It accepts a start-address/length command, drives the RAM's dual-port read address (DPRA), captures the asynchronous read data (DPO), and presents it as a valid/ready word stream with a last marker. It sits between the memory array, which a separate writer fills through the A/D/WE port, and any downstream consumer.

## Interface
Parameters:
- AW, 5, read address width; memory depth is 2^AW.
- DW, 32, data width, equal to the number of bit-sliced RAM32X1D instances.

Ports:
- clk  in  1  sole clock; the RAM's WCLK is driven from the same net.
- nreset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
- cmd_addr  in  AW  start address.
- cmd_len  in  AW  word count minus one (0 = 1 word, 2^AW−1 = full memory).
- rd_addr  out  AW  to DPRA[AW-1:0] of every RAM slice.
- rd_data  in  DW  from DPO of every RAM slice; combinational read of rd_addr.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DW  output word.
- out_last  out  1  marks the final word of a command.
- busy  out  1  a command is in flight or an output word is pending.

## Operation
- States: IDLE and STREAM.
  - cmd_ready = (state == IDLE).
  - busy = (state == STREAM) | out_valid.
- IDLE, when cmd_valid & cmd_ready:
  - addr_q <= cmd_addr, rem_q <= cmd_len.
  - state <= STREAM.
- STREAM, on each cycle where the slot is free (slot free = !out_valid | out_ready):
  - out_data <= rd_data, out_valid <= 1, out_last <= (rem_q == 0).
  - addr_q <= addr_q + 1, modulo 2^AW. 31 wraps to 0 with no error.
  - rem_q <= rem_q − 1.
  - If rem_q == 0, state <= IDLE.
- When the slot is not free, addr_q, rem_q and all output registers hold.
- Outside STREAM, out_valid clears on out_ready.
- rd_addr = addr_q at all times, so it is stable whenever a capture occurs.
- Write collision: if the writer writes address addr_q on the same edge that captures it, the captured value is the pre-write content. No bypass is provided.
- out_data, out_last and out_valid hold steady while out_valid & !out_ready.
- A new command is not accepted until the FSM returns to IDLE. Output of the previous command may still be draining when the new command is accepted; ordering is preserved.
- Reset values (nreset low, asynchronous): state IDLE, addr_q 0, rem_q 0, out_valid 0, out_data 0, out_last 0. Therefore rd_addr = 0, cmd_ready = 1, busy = 0.
- Reset asserted mid-command discards the remaining words and any pending output immediately. There is no partial-last word.

## Timing
- Command handshake edge E0: the FSM enters STREAM and rd_addr = cmd_addr during cycle E0..E1.
- First word is captured at edge E1; out_valid is high after E1. Latency is 1 cycle from command acceptance to first valid word.
- With out_ready held high, throughput is 1 word per cycle. The last word is captured at edge E(len+1).
- cmd_ready rises after the last capture edge. The earliest next acceptance is that same cycle's edge, which gives one bubble cycle between commands.
- Backpressure: each cycle with out_valid & !out_ready stalls address advance by exactly one cycle.
- All outputs are registered except cmd_ready and busy, which decode registered state only. There is no combinational path from any input to any output.

## Structure
- Shared package `dpram_pkg`:
  - state encoding constants (IDLE = 1'b0, STREAM = 1'b1);
  - default AW = 5 and DW = 32 constants shared with the writer-side block.
- Single flat module; no sub-module is required.
- The RAM array (DW × RAM32X1D) is instantiated by the parent, not inside this block.

## Test plan
- Reset, then cmd_addr = 4, cmd_len = 3, out_ready = 1 → words mem[4..7] on 4 consecutive cycles starting one cycle after acceptance; out_last only on mem[7]; cmd_ready low for 4 cycles.
- Wrap: cmd_addr = 30, cmd_len = 3 → mem[30], mem[31], mem[0], mem[1]; last on mem[1].
- Backpressure: cmd_len = 7 with out_ready toggling 1,0,0,1,… → no word lost or duplicated; out_data stable while stalled; total 8 words in order.
- Full sweep: cmd_addr = 0, cmd_len = 31, memory preloaded with data = address × 0x01010101 → 32 words matching, one out_last; next command accepted after one bubble.
- Collision: the writer writes 0xDEADBEEF to address 5 on the capture edge of address 5 (old value 0x5) → 0x5 is streamed; a re-read returns 0xDEADBEEF.
- Reset mid-stream: nreset pulsed low after 2 of 8 words → out_valid = 0, rd_addr = 0, cmd_ready = 1 immediately; a fresh command then streams correctly.
